// File: rtl/regfile_mp_if.sv
// Bus between decode/write-back and the multi-read-port register file.
// The master drives the write port and read addresses; the slave returns read data and status.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic                    WE;
  logic [ADDR_W-1:0]       ND;
  logic [DATA_W-1:0]       DI;
  logic [NREAD*ADDR_W-1:0] N;
  logic [NREAD*DATA_W-1:0] Q;
  logic                    busy;
  logic                    wr_drop;

  modport master (output WE, ND, DI, N, input Q, busy, wr_drop);
  modport slave  (input WE, ND, DI, N, output Q, busy, wr_drop);
endinterface

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NREAD combinational read ports, clear sweep on reset.
// Optional build macro REGFILE_MP_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_mp #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                NREAD     = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   clr_ptr, clr_ptr_nxt;
  logic              wr_drop_q;
  logic              busy;
  logic              clr_we;
  logic              wr_en;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_ptr   <= clr_ptr_nxt;
      wr_drop_q <= busy & bus.WE;
    end
  end

  // Next-state logic: the sweep walks every entry once, then stops without wrapping.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    if (state == CLEAR) begin
      clr_ptr_nxt = clr_ptr + (ADDR_W + 1)'(1);
      if (clr_ptr == LAST_PTR) state_nxt = IDLE;
    end
  end

  // Output logic.
  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR);
    wr_en  = (state == IDLE) && bus.WE;
`ifdef REGFILE_MP_ZERO_REG_EN
    if (bus.ND == '0) wr_en = 1'b0;
`endif
  end

  // NOTE: the array has no reset branch; the sweep clears it, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)     mem[clr_ptr[ADDR_W-1:0]] <= RESET_VAL;
      else if (wr_en) mem[bus.ND]              <= bus.DI;
    end
  end

  // Read ports: busy override first, then write-through bypass, then the array.
  always_comb begin
    bus.Q   = '0;
    rd_addr = '0;
    rd_data = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_addr = bus.N[k*ADDR_W +: ADDR_W];
      if (busy)                              rd_data = RESET_VAL;
      else if (bus.WE && rd_addr == bus.ND)  rd_data = bus.DI;
      else                                   rd_data = mem[rd_addr];
`ifdef REGFILE_MP_ZERO_REG_EN
      if (rd_addr == '0) rd_data = '0;
`endif
      bus.Q[k*DATA_W +: DATA_W] = rd_data;
    end
  end

  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;
endmodule
